neuron_mac: RTL
===============

# neuron_mac

Sequencing multiply-accumulate neuron that sits on the consuming side of the three-input operand buffer. It waits for the buffer's `ready`, steps the buffer's select through inputs 1..3 and accumulates `x*w` on top of a bias. It then writes a saturated fixed-point result and pulses `neuron_done` so the buffer clears its capture flags for the next operand set.

## Interface
- `DW`, 16: operand/result width, signed two's complement.
- `FRAC`, 8: fractional bits of `x`, `w`, `bias` and `y` (Q8.8 at defaults).
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `ready` input 1: all three operand slots in the buffer are captured.
- `x` input DW: operand selected by `sel`, signed.
- `w` input DW: weight selected by `sel`, signed.
- `bias` input DW: neuron bias, signed, same Q format as `x`.
- `sel` output 2: buffer operand select; 0 = none, 1..3 = slot.
- `neuron_done` output 1: one-cycle pulse; buffer clears its flags on it.
- `y` output DW: registered neuron result, Q format as `x`.
- `y_valid` output 1: one-cycle pulse, `y` updated this cycle.

## Operation
- Moore FSM states: IDLE, S1, S2, S3, DONE.
- IDLE: `sel`=0. If `ready`=1: load `acc <= sign_ext(bias) << FRAC`, go S1; else stay.
- S1/S2/S3: `sel`=1/2/3; `acc <= acc + x*w` (full 2*DW signed product). From S3, compute the final sum (acc + product) and register `y` from it; go DONE.
- DONE: `y_valid`=1, `neuron_done`=1, `sel`=0; unconditionally return to IDLE.
- Accumulator width 2*DW+2 (34 bits default); no overflow internally possible for 3 products + bias.
- Result: `sum >>> FRAC` (arithmetic shift, floor toward −∞), then saturate to [−2^(DW−1), 2^(DW−1)−1].
- `ready` ignored outside IDLE; `x`/`w` only sampled in S1..S3; `bias` only sampled in IDLE on accept.
- `y` holds its value between results.

## Timing
- Reset values: state IDLE, `sel`=0, `neuron_done`=0, `y_valid`=0, `y`=0, `acc`=0.
- `ready` high at edge ending cycle T (IDLE) → `sel`=1,2,3 in T+1..T+3 → `y`/`y_valid`/`neuron_done` in T+4 → IDLE in T+5.
- Throughput: one neuron per 5 cycles minimum.
- The buffer clears its flags at the edge ending DONE, so `ready` is 0 when IDLE is re-entered. A `ready` of 1 seen in IDLE is always a new set.
- Reset mid-operation, in any state: next cycle IDLE with all outputs at reset values; no `y_valid`/`neuron_done` for the aborted set. `y` returns to 0.
- `sel`, `neuron_done` and `y_valid` decode from state only; there is no combinational path from `ready`/`x`/`w`.

## Configuration
- `NEURON_RELU_EN` defined: after saturation, negative results are forced to 0. `y` is never negative.
- `NEURON_RELU_EN` undefined: `y` is the signed saturated sum; negative values pass through.

## Test plan
- Basic: `x`=0x0100 and `w`=0x0200 in all three slots, `bias`=0x0080, `ready` pulsed → `sel` 1,2,3 on consecutive cycles, then `y`=0x0680 (6.5) with `y_valid`=`neuron_done`=1 for exactly one cycle, 4 cycles after accept.
- Negative/ReLU: `x`=0x0100, `w`=0xFF00 ×3, `bias`=0 → `y`=0xFD00 without `NEURON_RELU_EN`; `y`=0x0000 with it.
- Saturation: `x`=`w`=0x7FFF ×3, `bias`=0x7FFF → `y`=0x7FFF. `x`=0x8000, `w`=0x7FFF ×3, `bias`=0 → `y`=0x8000 (ReLU off).
- Floor rounding: `x`=0x0001, `w`=0xFFFF in slot 1, zeros in slots 2..3, `bias`=0 → `y`=0xFFFF (−1 LSB), ReLU off.
- Reset in S2 → next cycle `sel`=0, `y`=0, no `y_valid`/`neuron_done`. Then `ready` reasserted → full normal sequence and correct result.
- Back-to-back: buffer refills immediately after `neuron_done` → second accept no earlier than IDLE re-entry. Two distinct results arrive 5 cycles apart, and `ready` never causes a double accept.

Source files
------------

// File: rtl/neuron_mac.sv
// neuron_mac: three-input sequencing multiply-accumulate neuron.
// It waits for the operand buffer's ready signal, then steps sel through
// slots 1..3 and accumulates x*w on top of the bias. The result is
// floor-shifted back to Q(DW-FRAC).FRAC, saturated, registered on y, and
// announced with single-cycle y_valid / neuron_done pulses.
// Optional feature: define NEURON_RELU_EN to clamp negative results to 0.
module neuron_mac #(
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] bias,
  output logic [1:0]    sel,
  output logic          neuron_done,
  output logic [DW-1:0] y,
  output logic          y_valid
);

  // Two guard bits cover three full products plus the shifted bias.
  localparam int AW = 2*DW + 2;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] S1   = 3'd1;
  localparam logic [2:0] S2   = 3'd2;
  localparam logic [2:0] S3   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  // Saturation bounds, sign-extended to the accumulator width.
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [2:0]             state;
  logic signed [AW-1:0]   acc;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext, bias_ext, sum, shifted;
  logic [DW-1:0]          y_sat, y_next;

  // Full-width signed product; the sign-extended operands make the low
  // 2*DW bits of the product exact.
  assign prod     = $signed({{DW{x[DW-1]}}, x}) * $signed({{DW{w[DW-1]}}, w});
  assign prod_ext = {{2{prod[2*DW-1]}}, prod};
  assign bias_ext = {{(AW-DW-FRAC){bias[DW-1]}}, bias, {FRAC{1'b0}}};
  assign sum      = acc + prod_ext;
  // Arithmetic shift floors toward minus infinity.
  assign shifted  = sum >>> FRAC;

  // Clamp to the representable range, then apply the optional ReLU.
  always_comb begin
    y_sat = shifted[DW-1:0];
    if (shifted > MAXV)      y_sat = MAXV[DW-1:0];
    else if (shifted < MINV) y_sat = MINV[DW-1:0];
`ifdef NEURON_RELU_EN
    y_next = y_sat[DW-1] ? '0 : y_sat;
`else
    y_next = y_sat;
`endif
  end

  // Sequencer: accept in IDLE, accumulate slots 1..3, publish in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      y     <= '0;
    end else begin
      case (state)
        IDLE: if (ready) begin
          acc   <= bias_ext;
          state <= S1;
        end
        S1: begin
          acc   <= sum;
          state <= S2;
        end
        S2: begin
          acc   <= sum;
          state <= S3;
        end
        S3: begin
          acc   <= sum;
          y     <= y_next;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore outputs: decoded from the state register only.
  always_comb begin
    sel         = 2'd0;
    neuron_done = 1'b0;
    y_valid     = 1'b0;
    case (state)
      S1:   sel = 2'd1;
      S2:   sel = 2'd2;
      S3:   sel = 2'd3;
      DONE: begin
        neuron_done = 1'b1;
        y_valid     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
